// File: rtl/spi_pkg.sv
// Shared SPI flash definitions: FSM states and command opcodes.
// Also used by the flash controller side of the link.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } spi_state_e;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes sclk/cs_n/mosi into clk and generates sclk and cs_n edge pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_n_s,
    output logic mosi_s,
    output logic settled
);

    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr, settle_sr;
    logic                   sclk_prev, cs_prev, sclk_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr   <= '0;
            cs_sr     <= '1;
            mosi_sr   <= '0;
            settle_sr <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sr[0]   <= sclk;
            cs_sr[0]     <= cs_n;
            mosi_sr[0]   <= mosi;
            settle_sr[0] <= 1'b1;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sr[i]   <= sclk_sr[i-1];
                cs_sr[i]     <= cs_sr[i-1];
                mosi_sr[i]   <= mosi_sr[i-1];
                settle_sr[i] <= settle_sr[i-1];
            end
            sclk_prev <= sclk_s;
            cs_prev   <= cs_n_s;
        end
    end

    assign sclk_s  = sclk_sr[SYNC_STAGES-1];
    assign cs_n_s  = cs_sr[SYNC_STAGES-1];
    assign mosi_s  = mosi_sr[SYNC_STAGES-1];
    // settled marks the chains as holding real pin values rather than reset fill
    assign settled = settle_sr[SYNC_STAGES-1];

    assign sclk_rise = ~cs_n_s & sclk_s & ~sclk_prev;
    assign sclk_fall = ~cs_n_s & ~sclk_s & sclk_prev;
    assign cs_rise   = cs_n_s & ~cs_prev;
    assign cs_fall   = ~cs_n_s & cs_prev;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder: READ (0x03) with one-byte prefetch and JEDEC ID (0x9F).
module spi_flash_resp
    import spi_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        busy,
    output logic        underrun
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s, mosi_s, settled;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s),
        .settled  (settled)
    );

    spi_state_e  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] rx_q, rx_d, rx_in;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  buf_q, buf_d, byte_in;
    logic        buf_vld_q, buf_vld_d, have_byte;
    logic        miso_q, miso_d, oe_q, oe_d, req_q, req_d, under_q, under_d;
    logic [23:0] addr_q, addr_d;
    logic        busy_q, armed_q;

    assign rx_in     = {rx_q[22:0], mosi_s};
    assign have_byte = buf_vld_q | (req_q & mem_ack);
    assign byte_in   = buf_vld_q ? buf_q : mem_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '1;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            miso_q    <= 1'b1;
            oe_q      <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            under_q   <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            under_q   <= under_d;
            busy_q    <= ~cs_n_s;
            // a transaction cut by reset is ignored until cs_n is really seen high
            armed_q   <= armed_q | (settled & cs_n_s);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        req_d     = req_q;
        addr_d    = addr_q;
        under_d   = under_q;

        if (cs_rise) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            miso_d    = 1'b1;
            req_d     = 1'b0;
            buf_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        tx_d      = '1;
                        buf_vld_d = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d      = rx_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            if (rx_in[7:0] == CMD_READ) begin
                                state_d = ADDR;
                            end else if (rx_in[7:0] == CMD_JEDEC) begin
                                state_d = ID;
                                tx_d    = {JEDEC_ID, 8'hFF};
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        rx_d      = rx_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_in;
                            req_d     = 1'b1;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (req_q && mem_ack) begin
                        req_d     = 1'b0;
                        buf_d     = mem_data;
                        buf_vld_d = 1'b1;
                    end
                    if (sclk_fall) begin
                        oe_d      = 1'b1;
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            if (have_byte) begin
                                miso_d    = byte_in[7];
                                tx_d      = {byte_in[6:0], 25'h1FFFFFF};
                                buf_vld_d = 1'b0;
                                req_d     = 1'b1;
                                addr_d    = addr_q + 24'd1;
                            end else begin
                                // fetch still outstanding: pad with FF, keep the request
                                miso_d  = 1'b1;
                                tx_d    = '1;
                                under_d = 1'b1;
                            end
                        end else begin
                            miso_d = tx_q[31];
                            tx_d   = {tx_q[30:0], 1'b1};
                        end
                    end
                end
                ID: begin
                    if (sclk_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b1};
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign miso     = oe_q ? miso_q : 1'b1;
    assign miso_oe  = oe_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign underrun = under_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: READ, JEDEC ID, wrap, underrun, abort, ignore, reset.
module tb_spi_flash_resp;

    localparam int unsigned SYNC_STAGES = 2;

    logic        clk, rst, sclk, cs_n, mosi, miso, miso_oe, mem_req, mem_ack, busy, underrun;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;

    int          n_chk = 0;
    int          n_bad = 0;
    int          ack_delay, cnt;
    bit          req_seen, oe_seen;
    logic [23:0] addr_log[$];
    logic [31:0] rx;

    spi_flash_resp #(
        .JEDEC_ID   (24'hEF4016),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .mem_addr(mem_addr),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_data(mem_data),
        .busy    (busy),
        .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h000100) return 8'hA5;
        if (a == 24'h000101) return 8'h3C;
        return a[7:0] ^ 8'h5A;
    endfunction

    // backing store: acks ack_delay cycles after a request, logs each new request address
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        cnt      = 0;
        forever begin
            @(negedge clk);
            if (mem_req) req_seen = 1'b1;
            if (miso_oe) oe_seen = 1'b1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (cnt == 0) addr_log.push_back(mem_addr);
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_byte(mem_addr);
                    cnt      = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Mode 0: drive mosi while sclk low, sample miso just before the rise
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx_o);
        rx_o = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #80;
            rx_o = {rx_o[30:0], miso};
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        req_seen = 1'b0;
        oe_seen  = 1'b0;
        addr_log.delete();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80;
        cs_n = 1'b1;
        #400;
    endtask

    task automatic jedec_txn(input string tag);
        cs_begin();
        spi_bits(32'h9F, 8, rx);
        spi_bits(32'h0, 32, rx);
        check_eq(tag, rx, 32'hEF4016FF);
        cs_end();
    endtask

    initial begin
        sclk      = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        ack_delay = 2;
        rst       = 1'b1;
        #30;
        rst = 1'b0;
        #20;
        check_eq("rst_miso", miso, 1);
        check_eq("rst_oe", miso_oe, 0);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_underrun", underrun, 0);

        // READ 0x000100, two bytes
        cs_begin();
        check_eq("rd_busy", busy, 1);
        spi_bits(32'h03000100, 32, rx);
        spi_bits(32'h0, 8, rx);
        check_eq("rd_byte0", rx, 32'hA5);
        spi_bits(32'h0, 8, rx);
        check_eq("rd_byte1", rx, 32'h3C);
        cs_end();
        check_eq("rd_nreq", addr_log.size(), 4);
        check_eq("rd_addr0", addr_log[0], 24'h000100);
        check_eq("rd_addr1", addr_log[1], 24'h000101);
        check_eq("rd_underrun", underrun, 0);
        check_eq("rd_idle_busy", busy, 0);

        jedec_txn("jedec");

        // address wrap
        cs_begin();
        spi_bits(32'h03FFFFFF, 32, rx);
        spi_bits(32'h0, 16, rx);
        check_eq("wrap_data", rx, 32'hA55A);
        cs_end();
        check_eq("wrap_addr0", addr_log[0], 24'hFFFFFF);
        check_eq("wrap_addr1", addr_log[1], 24'h000000);

        // unknown command
        cs_begin();
        spi_bits(32'h05, 8, rx);
        spi_bits(32'h0, 16, rx);
        check_eq("ign_miso", rx, 32'hFFFF);
        cs_end();
        check_eq("ign_oe", oe_seen, 0);
        check_eq("ign_req", req_seen, 0);

        // abort after 12 address bits
        cs_begin();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'h0, 12, rx);
        cs_n = 1'b1;
        #((SYNC_STAGES + 2) * 10);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_oe", miso_oe, 0);
        #400;
        check_eq("abort_req", req_seen, 0);
        jedec_txn("abort_jedec");

        // reset in the middle of a READ: rest of transaction ignored
        cs_begin();
        spi_bits(32'h0300, 16, rx);
        rst = 1'b1;
        #30;
        rst = 1'b0;
        req_seen = 1'b0;
        oe_seen  = 1'b0;
        spi_bits(32'h0100, 16, rx);
        spi_bits(32'h0, 8, rx);
        check_eq("mrst_miso", rx, 32'hFF);
        cs_end();
        check_eq("mrst_req", req_seen, 0);
        check_eq("mrst_oe", oe_seen, 0);
        jedec_txn("mrst_jedec");

        // late ack: first byte underruns, second byte carries the late data
        ack_delay = 130;
        cs_begin();
        spi_bits(32'h03000200, 32, rx);
        spi_bits(32'h0, 8, rx);
        check_eq("ur_byte0", rx, 32'hFF);
        check_eq("ur_flag", underrun, 1);
        spi_bits(32'h0, 8, rx);
        check_eq("ur_byte1", rx, 32'h5A);
        cs_end();
        check_eq("ur_addr0", addr_log[0], 24'h000200);
        check_eq("ur_addr1", addr_log[1], 24'h000201);
        check_eq("ur_req_drop", mem_req, 0);
        check_eq("ur_sticky", underrun, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_resp.md
SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

Interface
REQ-001 SHALL have parameter JEDEC_ID, default 24'hEF4016, the 3-byte ID returned by command 0x9F, MSB byte first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for sclk, cs_n and mosi.
REQ-003 SHALL have port clk  input  1  the single system clock; every flop is in this domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi  input  1  SPI controller-to-responder data, asynchronous.
REQ-008 SHALL have port miso  output  1  SPI responder-to-controller data.
REQ-009 SHALL have port miso_oe  output  1  miso output enable; high only while a response is being shifted.
REQ-010 SHALL have port mem_addr  output  24  byte address of the backing-store fetch.
REQ-011 SHALL have port mem_req  output  1  fetch request; held high until mem_ack.
REQ-012 SHALL have port mem_ack  input  1  single-cycle fetch completion; mem_data is valid in the same cycle.
REQ-013 SHALL have port mem_data  input  8  fetched byte.
REQ-014 SHALL have port busy  output  1  high while cs_n is asserted (synchronized).
REQ-015 SHALL have port underrun  output  1  sticky flag; set when a byte is needed before its fetch completed; cleared by rst only.

Function
REQ-016 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, then detect sclk rise/fall edges on the synchronized values; clk is at least 4x the sclk frequency.
REQ-017 SHALL implement SPI mode 0: mosi sampled on sclk rise, miso changed on sclk fall, MSB first.
REQ-018 SHALL use states IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-019 IDLE: on cs_n falling go to CMD with the bit counter at 0.
REQ-020 CMD: after 8 rising edges, byte 0x03 goes to ADDR, 0x9F goes to ID, and any other byte goes to IGNORE.
REQ-021 ADDR: shift 24 bits; after the 24th rise, load the address, assert mem_req with mem_addr=address, and go to DATA.
REQ-022 DATA: on the sclk fall after the last address bit, drive bit 7 of the fetched byte with miso_oe=1; shift out one bit per subsequent fall.
REQ-023 DATA: on each byte's first-bit fall, request address+1 (prefetch); the address wraps from 24'hFFFFFF to 0.
REQ-024 DATA: if mem_ack has not arrived when a byte must start, shift 8'hFF for that byte, set underrun, and keep the outstanding request; a late ack is consumed for the next byte.
REQ-025 ID: shift out JEDEC_ID's 24 bits from the fall after the command byte, then shift 1s while cs_n stays low.
REQ-026 IGNORE: keep miso_oe=0 and take no action until cs_n rises.
REQ-027 SHALL, on synchronized cs_n rising in any state, go to IDLE the next cycle, drive miso_oe=0, and drop mem_req without waiting for mem_ack; an ack arriving after this is ignored.
REQ-028 SHALL discard sclk edges while cs_n is high.
REQ-029 SHALL drive miso=1 whenever miso_oe=0.

Reset
REQ-030 On rst SHALL set state=IDLE, miso=1, miso_oe=0, mem_req=0, mem_addr=0, busy=0, underrun=0, clear counters and shift registers, and load the synchronizer flops with sclk=0, cs_n=1, mosi=0.
REQ-031 SHALL treat rst asserted mid-transaction like reset, then ignore the rest of the transaction until cs_n is seen high.

Structure
REQ-032 SHALL place the state enum and the command constants (CMD_READ=8'h03, CMD_JEDEC=8'h9F) in shared package spi_pkg, also used by the flash controller.
REQ-033 SHALL instantiate one sub-module, spi_sync_edge: the synchronizer plus sclk rise/fall pulse generator.

Verification
REQ-034 Test: cs_n low, send 03 00 01 00, mem returns 8'hA5 then 8'h3C with a 2-cycle ack -> miso reads A5 3C, mem_addr 0x000100 then 0x000101.
REQ-035 Test: send 9F, clock 32 bits -> miso reads EF 40 16 FF.
REQ-036 Test: send 03 FF FF FF, read 2 bytes -> mem_addr 0xFFFFFF then 0x000000.
REQ-037 Test: hold mem_ack off for more than 8 sclk periods after the address -> first byte reads FF, underrun=1, and the second byte is the late-acked data.
REQ-038 Test: raise cs_n after 12 address bits -> IDLE within SYNC_STAGES+2 cycles, mem_req never asserted; the next 9F transaction is correct.
REQ-039 Test: send 0x05 -> miso_oe stays 0 for the whole transaction and mem_req is never asserted.
